// File: rtl/hci_package.sv
// Shared types and constants for the HCI core response tracker.
package hci_package;

    localparam int unsigned HCI_RSP_DW = 32;
    localparam int unsigned HCI_RSP_IW = 8;
    localparam int unsigned HCI_RSP_UW = 2;

    localparam int unsigned HCI_RSP_TRACKER_MIN_DEPTH = 2;

    typedef struct packed {
        logic [HCI_RSP_IW-1:0] id;
        logic [HCI_RSP_UW-1:0] user;
    } rsp_tag_t;

    typedef struct packed {
        logic [HCI_RSP_DW-1:0] data;
        rsp_tag_t              tag;
    } rsp_entry_t;

endpackage

// File: rtl/hci_core_rsp_tracker_fifo.sv
// Generic synchronous FIFO with full/empty flags; head is read straight from the storage registers.
module hci_core_rsp_tracker_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; empty_o guards every read of a stale slot.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/hci_core_rsp_tracker.sv
// Credit-based response tracker: tags TCDM responses with id/user and buffers them under r_ready stalls.
// Optional statistics outputs are enabled by defining HCI_CORE_RSP_TRACKER_STATS_EN.
module hci_core_rsp_tracker
    import hci_package::*;
#(
    parameter int unsigned DW              = HCI_RSP_DW,
    parameter int unsigned AW              = 32,
    parameter int unsigned UW              = HCI_RSP_UW,
    parameter int unsigned IW              = HCI_RSP_IW,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clear_i,
    input  logic                                 tgt_req_i,
    output logic                                 tgt_gnt_o,
    input  logic [AW-1:0]                        tgt_add_i,
    input  logic                                 tgt_wen_i,
    input  logic [DW/8-1:0]                      tgt_be_i,
    input  logic [DW-1:0]                        tgt_data_i,
    input  logic [IW-1:0]                        tgt_id_i,
    input  logic [UW-1:0]                        tgt_user_i,
    output logic                                 tgt_r_valid_o,
    input  logic                                 tgt_r_ready_i,
    output logic [DW-1:0]                        tgt_r_data_o,
    output logic [IW-1:0]                        tgt_r_id_o,
    output logic [UW-1:0]                        tgt_r_user_o,
    output logic                                 ini_req_o,
    input  logic                                 ini_gnt_i,
    output logic [AW-1:0]                        ini_add_o,
    output logic                                 ini_wen_o,
    output logic [DW/8-1:0]                      ini_be_o,
    output logic [DW-1:0]                        ini_data_o,
    input  logic                                 ini_r_valid_i,
    input  logic [DW-1:0]                        ini_r_data_i,
`ifdef HCI_CORE_RSP_TRACKER_STATS_EN
    output logic [31:0]                          stall_cnt_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] max_occ_o,
`endif
    output logic                                 err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [UW-1:0] user;
    } tag_t;

    typedef struct packed {
        logic [DW-1:0] data;
        tag_t          tag;
    } entry_t;

    if (MAX_OUTSTANDING < HCI_RSP_TRACKER_MIN_DEPTH) begin : g_depth_check
        $error("hci_core_rsp_tracker: MAX_OUTSTANDING must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          drop_q;
    logic          flush;
    logic          room;
    logic          gnt_fire, rsp_fire;
    logic          rsp_arrive, rsp_accept, bypass;
    logic          resp_push, resp_pop;
    logic          tag_full, tag_empty, resp_full, resp_empty;
    logic          unused_full;
    tag_t          tag_in, tag_head;
    entry_t        resp_in, resp_head, out_entry;

    assign flush = rst_i | clear_i;

    // Credit return is registered: a full tracker stays closed for the cycle of the handshake.
    assign room      = (cnt_q < CW'(MAX_OUTSTANDING));
    assign ini_req_o = tgt_req_i & room;
    assign tgt_gnt_o = ini_gnt_i & room;
    assign gnt_fire  = ini_req_o & ini_gnt_i;

    assign ini_add_o  = tgt_add_i;
    assign ini_wen_o  = tgt_wen_i;
    assign ini_be_o   = tgt_be_i;
    assign ini_data_o = tgt_data_i;

    assign rsp_arrive = ini_r_valid_i & ~drop_q;
    assign rsp_accept = rsp_arrive & ~tag_empty;
    assign bypass     = rsp_accept & resp_empty & tgt_r_ready_i;
    assign resp_push  = rsp_accept & ~bypass;
    assign resp_pop   = ~resp_empty & tgt_r_ready_i;

    assign tag_in       = '{id: tgt_id_i, user: tgt_user_i};
    assign resp_in.data = ini_r_data_i;
    assign resp_in.tag  = tag_head;
    assign out_entry    = resp_empty ? resp_in : resp_head;

    assign tgt_r_valid_o = ~resp_empty | bypass;
    assign tgt_r_data_o  = out_entry.data;
    assign tgt_r_id_o    = out_entry.tag.id;
    assign tgt_r_user_o  = out_entry.tag.user;
    assign rsp_fire      = tgt_r_valid_o & tgt_r_ready_i;
    assign err_o         = err_q;

    // The credit counter already keeps both FIFOs from overflowing.
    assign unused_full = tag_full ^ resp_full;

    hci_core_rsp_tracker_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (flush),
        .push_i  (gnt_fire),
        .data_i  (tag_in),
        .pop_i   (rsp_accept),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    hci_core_rsp_tracker_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (flush),
        .push_i  (resp_push),
        .data_i  (resp_in),
        .pop_i   (resp_pop),
        .data_o  (resp_head),
        .full_o  (resp_full),
        .empty_o (resp_empty)
    );

    always_comb begin
        cnt_d = cnt_q;
        case ({gnt_fire, rsp_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (rsp_arrive & tag_empty);
    end

    // drop_q masks the response of a request granted just before a flush.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            drop_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            drop_q <= 1'b0;
        end
    end

`ifdef HCI_CORE_RSP_TRACKER_STATS_EN
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] max_occ_q, max_occ_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (tgt_req_i & ~room & ~(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
        max_occ_d = (cnt_q > max_occ_q) ? cnt_q : max_occ_q;
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            stall_cnt_q <= '0;
            max_occ_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            max_occ_q   <= max_occ_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign max_occ_o   = max_occ_q;
`endif

endmodule

// File: doc/hci_core_rsp_tracker.md
Name: hci_core_rsp_tracker

Overview:
- Per-channel stage directly downstream of each split output channel, between it and the TCDM interconnect port.
- TCDM banks return r_valid/r_data one cycle after grant, with no backpressure and no ID. The split stage, however, stalls its channels via r_ready.
- This block tracks outstanding transactions and attaches the request's id/user to each response. It buffers responses while r_ready is low and throttles grants so the buffer can never overflow.

Parameters:
- DW, 32: data width of the channel.
- AW, 32: address width.
- UW, 2: user width.
- IW, 8: id width.
- MAX_OUTSTANDING, 4: response-buffer depth and credit limit; must be ≥2 (elaborate-time assert).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous soft clear; same effect as rst_i
- tgt_req_i  in  1  upstream request
- tgt_gnt_o  out  1  upstream grant
- tgt_add_i  in  AW  address
- tgt_wen_i  in  1  1=read, 0=write
- tgt_be_i  in  DW/8  byte enables
- tgt_data_i  in  DW  write data
- tgt_id_i  in  IW  transaction id
- tgt_user_i  in  UW  user bits
- tgt_r_valid_o  out  1  response valid
- tgt_r_ready_i  in  1  response ready
- tgt_r_data_o  out  DW  response data
- tgt_r_id_o  out  IW  id of the originating request
- tgt_r_user_o  out  UW  user bits of the originating request
- ini_req_o  out  1  memory-side request
- ini_gnt_i  in  1  memory-side grant
- ini_add_o / ini_wen_o / ini_be_o / ini_data_o  out  AW/1/DW/8/DW  forwarded combinationally from tgt_*
- ini_r_valid_i  in  1  memory response; exactly 1 cycle after each grant (reads and writes)
- ini_r_data_i  in  DW  memory response data
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Credit counter `cnt`, width $clog2(MAX_OUTSTANDING+1), counts granted but not yet delivered transactions.
  - cnt += 1 on a grant (ini_req_o & ini_gnt_i).
  - cnt -= 1 on a response handshake (tgt_r_valid_o & tgt_r_ready_i).
  - Both in the same cycle: cnt unchanged.
- Request gating:
  - `room` = (cnt < MAX_OUTSTANDING).
  - ini_req_o = tgt_req_i & room.
  - tgt_gnt_o = ini_gnt_i & room.
  - Purely combinational; zero-latency request path.
- Tag FIFO (depth MAX_OUTSTANDING, entries {id,user}):
  - Push on grant.
  - Pop when the matching response is pushed into the response path, i.e. on ini_r_valid_i.
- Response FIFO (depth MAX_OUTSTANDING, entries {r_data,id,user}):
  - Push on ini_r_valid_i with data from ini_r_data_i and tag from the tag-FIFO head.
  - tgt_r_valid_o = ~resp_empty, or ini_r_valid_i in bypass mode.
- Bypass: when the response FIFO is empty and tgt_r_ready_i=1, an arriving response goes straight to tgt_r_* in the same cycle and is not stored. Response latency is then 1 cycle from grant.
- Ordering: responses are strictly in grant order. A response stays stable while tgt_r_valid_o=1 and tgt_r_ready_i=0.
- Overflow impossible by construction: cnt ≤ MAX_OUTSTANDING bounds tag FIFO plus response FIFO occupancy.
- Protocol error: if ini_r_valid_i=1 while the tag FIFO is empty, set err_o=1 (sticky) and drop the response. Only rst_i or clear_i clears err_o.
- Reset/clear (synchronous, highest priority):
  - cnt=0, both FIFOs empty, err_o=0.
  - tgt_r_valid_o=0, tgt_gnt_o=ini_gnt_i&1, ini_req_o=tgt_req_i.
  - A response arriving in the cycle after a mid-operation clear is ignored, not counted as an error. A one-cycle `drop_q` flag, set by clear, masks it.
- Boundary cases:
  - cnt==MAX_OUTSTANDING with a simultaneous response handshake: room stays 0 this cycle (no combinational credit return). The grant is possible next cycle.
  - Response FIFO full cannot coincide with a push, because the credit invariant prevents it.

Optional Feature:
- HCI_CORE_RSP_TRACKER_STATS_EN defined:
  - Adds output stall_cnt_o (32 bit): counts cycles with tgt_req_i & ~room; saturates at 2^32-1.
  - Adds output max_occ_o ($clog2(MAX_OUTSTANDING+1) bit): high-water mark of cnt.
  - Both are zeroed by rst_i/clear_i.
- Undefined: neither port nor its logic exists.

Decomposition:
- hci_package: typedefs `rsp_tag_t` {id,user} and `rsp_entry_t` {data,tag}, parameterised via localparam widths; constant HCI_RSP_TRACKER_MIN_DEPTH=2.
- Sub-module hci_core_rsp_tracker_fifo: generic synchronous FIFO with full/empty flags and a registered head. Instantiated twice, once for the tag FIFO and once for the response FIFO.

Test Plan:
- Always-ready: 8 back-to-back reads ids 0..7, gnt=1, r_ready=1 → each r_valid 1 cycle after its grant; r_id 0..7 in order; cnt never exceeds 1.
- Backpressure: r_ready=0; issue reads until tgt_gnt_o drops → exactly 4 grants (MAX_OUTSTANDING=4), ini_req_o=0 afterwards. Raise r_ready → 4 responses in order with data intact, then grants resume.
- Simultaneous grant and response handshake at cnt=2 → cnt stays 2; tag and data pairing stays correct.
- Grant denied (ini_gnt_i=0 for 3 cycles) → no tag pushed, cnt unchanged, tgt_gnt_o=0.
- Spurious ini_r_valid_i with no outstanding transaction → err_o=1 next cycle and stays high until clear_i; no tgt_r_valid_o.
- clear_i with 3 outstanding → next cycle cnt=0, tgt_r_valid_o=0. The in-flight response arriving the cycle after is dropped without asserting err_o.
